// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of a 5-stage MIPS pipeline.
//
// Owns the program counter, presents it to instruction memory and captures
// the returned word into the IF/ID pipeline register. Honours hazard-unit
// stalls, flushes and branch/jump redirects resolved in ID.
//
// Optional build macro: IF_STAGE_PERF_CNT_EN
//   When defined, adds o_fetch_count / o_bubble_count performance counters.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          synchronous, active-high reset
//   i_stall          hold PC and IF/ID contents
//   i_flush          replace IF/ID contents with a bubble
//   i_redirect_valid load i_redirect_pc into PC (taken branch/jump)
//   i_redirect_pc    redirect target, bits [1:0] ignored
//   o_im_addr        byte address to instruction memory (= PC)
//   i_im_instr       instruction word returned combinationally for o_im_addr
//   o_ifid_instr     IF/ID instruction register
//   o_ifid_pc4       IF/ID PC+4 register
//   o_ifid_valid     IF/ID holds a real instruction (0 = bubble)
//   o_fetch_count    (perf build) count of real fetches into IF/ID
//   o_bubble_count   (perf build) count of bubbles loaded into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_instr,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_bubble_count
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_pc4;
  logic [31:0] w_redirect_aligned;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;

  // Wraps modulo 2^32 naturally.
  assign w_pc4              = r_pc + 32'd4;
  assign w_redirect_aligned = i_redirect_pc & 32'hFFFF_FFFC;

  // Next-value selection in priority order: redirect, stall+flush, stall,
  // flush, normal advance. ifid_pc4 is only refreshed on a real fetch.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_ifid_instr;
    w_pc4_nxt   = r_ifid_pc4;
    w_valid_nxt = r_ifid_valid;
    if (i_redirect_valid) begin
      w_pc_nxt    = w_redirect_aligned;
      w_instr_nxt = NOP_WORD;
      w_valid_nxt = 1'b0;
    end else if (i_stall && i_flush) begin
      w_instr_nxt = NOP_WORD;
      w_valid_nxt = 1'b0;
    end else if (i_stall) begin
      // hold everything
    end else if (i_flush) begin
      w_pc_nxt    = w_pc4;
      w_instr_nxt = NOP_WORD;
      w_valid_nxt = 1'b0;
    end else begin
      w_pc_nxt    = w_pc4;
      w_instr_nxt = i_im_instr;
      w_pc4_nxt   = w_pc4;
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_instr_nxt;
      r_ifid_pc4   <= w_pc4_nxt;
      r_ifid_valid <= w_valid_nxt;
    end
  end

  assign o_im_addr    = r_pc;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_pc4   = r_ifid_pc4;
  assign o_ifid_valid = r_ifid_valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;
  logic        w_fetch;
  logic        w_bubble;

  // Any redirect or flush loads a bubble; a fetch needs no hazard input.
  assign w_fetch  = !i_redirect_valid && !i_stall && !i_flush;
  assign w_bubble = i_redirect_valid || i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_fetch)  r_fetch_count  <= r_fetch_count + 32'd1;
      if (w_bubble) r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign o_fetch_count  = r_fetch_count;
  assign o_bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_im_addr       (im_addr),
    .i_im_instr      (im_instr),
    .o_ifid_instr    (ifid_instr),
    .o_ifid_pc4      (ifid_pc4),
    .o_ifid_valid    (ifid_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .o_fetch_count   (fetch_count),
    .o_bubble_count  (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two real words, everything else a tag of its address.
  always_comb begin
    if (im_addr == 32'h0)      im_instr = 32'h2011_0012;
    else if (im_addr == 32'h4) im_instr = 32'h2010_0008;
    else                       im_instr = {8'hA5, im_addr[23:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] a, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
    chk({tag, ".im_addr"}, im_addr, a);
    chk({tag, ".instr"}, ifid_instr, ins);
    chk({tag, ".pc4"}, ifid_pc4, p4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    step(); step();
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("reset.fetch_cnt", fetch_count, 32'd0);
    chk("reset.bubble_cnt", bubble_count, 32'd0);
`endif

    reset = 1'b0;
    step();
    chk_ifid("fetch1", 32'h4, 32'h2011_0012, 32'h4, 1'b1);
    step();
    chk_ifid("fetch2", 32'h8, 32'h2010_0008, 32'h8, 1'b1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("stall_hold", 32'h8, 32'h2010_0008, 32'h8, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_ifid("stall_release", 32'hC, 32'hA500_0008, 32'hC, 1'b1);

    // Advance 0xC -> 0x28.
    for (int i = 0; i < 7; i++) step();
    chk_ifid("run_to_40", 32'h28, 32'hA500_0024, 32'h28, 1'b1);

    redirect_valid = 1'b1; redirect_pc = 32'h0000_004E;
    step();
    chk_ifid("redirect", 32'h4C, 32'h0, 32'h28, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk_ifid("after_redirect", 32'h50, 32'hA500_004C, 32'h50, 1'b1);

    stall = 1'b1; flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    chk_ifid("redir_over_stall_flush", 32'h10, 32'h0, 32'h50, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk_ifid("stall_flush", 32'h10, 32'h0, 32'h50, 1'b0);

    stall = 1'b0;
    step();
    chk_ifid("flush_only", 32'h14, 32'h0, 32'h50, 1'b0);
    flush = 1'b0;

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    chk_ifid("redirect_top", 32'hFFFF_FFFC, 32'h0, 32'h50, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk_ifid("wrap", 32'h0, 32'hA5FF_FFFC, 32'h0, 1'b1);

    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    chk_ifid("reset_wins", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("reset_wins.fetch_cnt", fetch_count, 32'd0);
    chk("reset_wins.bubble_cnt", bubble_count, 32'd0);
`endif
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    for (int i = 0; i < 5; i++) step();
    chk_ifid("perf_fetch5", 32'h14, 32'hA500_0010, 32'h14, 1'b1);
    stall = 1'b1;
    step(); step();
    chk_ifid("perf_stall2", 32'h14, 32'hA500_0010, 32'h14, 1'b1);
    stall = 1'b0; flush = 1'b1;
    step();
    chk_ifid("perf_flush", 32'h18, 32'h0, 32'h14, 1'b0);
    flush = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk_ifid("perf_redirect", 32'h40, 32'h0, 32'h14, 1'b0);
    redirect_valid = 1'b0;
`ifdef IF_STAGE_PERF_CNT_EN
    chk("perf.fetch_cnt", fetch_count, 32'd5);
    chk("perf.bubble_cnt", bubble_count, 32'd2);
    reset = 1'b1;
    step();
    chk("perf_reset.fetch_cnt", fetch_count, 32'd0);
    chk("perf_reset.bubble_cnt", bubble_count, 32'd0);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
